// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Purpose  : 8N1 UART byte receiver feeding an 0xA5-framed register-write
//            command parser. Define UART_CMD_RX_CHECKSUM_EN for a 4-byte frame
//            with XOR check byte; otherwise frames are 0xA5, ADDR, DATA.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       clk10m,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [4:0] cfg_sel,
  output logic       cfg_run,
  output logic       cmd_stb,
  output logic [7:0] cmd_addr,
  output logic       err_stb
);

  localparam int CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [7:0]       C_SYNC_BYTE = 8'hA5;
  localparam logic [7:0]       C_ADDR_SEL  = 8'h01;
  localparam logic [7:0]       C_ADDR_RUN  = 8'h02;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

`ifdef UART_CMD_RX_CHECKSUM_EN
  typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CHK} p_state_t;
`else
  typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA} p_state_t;
`endif

  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_prev_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;

  p_state_t         p_state_q;
  logic [7:0]       addr_q;
  logic [TMO_W-1:0] tmo_q;

  logic [4:0]       cfg_sel_q;
  logic             cfg_run_q;
  logic             cmd_stb_q;
  logic [7:0]       cmd_addr_q;
  logic             err_stb_q;

  logic [7:0]       shift_d;
  logic             stop_sample_d;
  logic             byte_done_d;
  logic             frame_err_d;
  logic             cmd_last_d;
  logic             chk_ok_d;
  logic [4:0]       cmd_sel_d;
  logic             cmd_run_d;
  logic             addr_known_d;
  logic             cmd_ok_d;

  assign shift_d       = {rx_sync_q, shift_q[7:1]};
  assign stop_sample_d = (rx_state_q == RX_STOP) && (bit_cnt_q == C_BIT_LAST);
  assign byte_done_d   = stop_sample_d && rx_sync_q;
  assign frame_err_d   = stop_sample_d && !rx_sync_q;

`ifdef UART_CMD_RX_CHECKSUM_EN
  logic [7:0] data_q;

  // The byte completing this cycle is CHK; DATA was captured one byte earlier.
  assign cmd_last_d = (p_state_q == P_CHK);
  assign chk_ok_d   = (shift_q == (C_SYNC_BYTE ^ addr_q ^ data_q));
  assign cmd_sel_d  = data_q[4:0];
  assign cmd_run_d  = data_q[0];
`else
  assign cmd_last_d = (p_state_q == P_DATA);
  assign chk_ok_d   = 1'b1;
  assign cmd_sel_d  = shift_q[4:0];
  assign cmd_run_d  = shift_q[0];
`endif

  assign addr_known_d = (addr_q == C_ADDR_SEL) || (addr_q == C_ADDR_RUN);
  assign cmd_ok_d     = chk_ok_d && addr_known_d;

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      p_state_q  <= P_HUNT;
      addr_q     <= '0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      data_q     <= '0;
`endif
      tmo_q      <= '0;
      cfg_sel_q  <= '0;
      cfg_run_q  <= 1'b0;
      cmd_stb_q  <= 1'b0;
      cmd_addr_q <= '0;
      err_stb_q  <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      cmd_stb_q <= 1'b0;
      err_stb_q <= 1'b0;
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);

      case (rx_state_q)
        RX_IDLE: begin
          bit_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (bit_cnt_q == C_HALF_LAST) begin
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == C_BIT_LAST) begin
            bit_cnt_q <= '0;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (stop_sample_d) begin
            bit_cnt_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          bit_cnt_q <= '0;
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase

      // A completed byte always outranks the timeout, so both strobes stay exclusive.
      if (byte_done_d) begin
        tmo_q <= '0;
        case (p_state_q)
          P_HUNT: if (shift_q == C_SYNC_BYTE) p_state_q <= P_ADDR;
          P_ADDR: begin
            addr_q    <= shift_q;
            p_state_q <= P_DATA;
          end
`ifdef UART_CMD_RX_CHECKSUM_EN
          P_DATA: begin
            data_q    <= shift_q;
            p_state_q <= P_CHK;
          end
          P_CHK:  p_state_q <= P_HUNT;
`else
          P_DATA: p_state_q <= P_HUNT;
`endif
          default: p_state_q <= P_HUNT;
        endcase

        if (cmd_last_d) begin
          if (cmd_ok_d) begin
            cmd_stb_q  <= 1'b1;
            cmd_addr_q <= addr_q;
            if (addr_q == C_ADDR_SEL) cfg_sel_q <= cmd_sel_d;
            if (addr_q == C_ADDR_RUN) cfg_run_q <= cmd_run_d;
          end else begin
            err_stb_q <= 1'b1;
          end
        end
      end else if (frame_err_d) begin
        err_stb_q <= 1'b1;
        p_state_q <= P_HUNT;
        tmo_q     <= '0;
      end else if (p_state_q != P_HUNT) begin
        if (tmo_q == C_TMO_LAST) begin
          err_stb_q <= 1'b1;
          p_state_q <= P_HUNT;
          tmo_q     <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end
    end
  end

  assign cfg_sel  = cfg_sel_q;
  assign cfg_run  = cfg_run_q;
  assign cmd_stb  = cmd_stb_q;
  assign cmd_addr = cmd_addr_q;
  assign err_stb  = err_stb_q;

endmodule
`default_nettype wire
